// File: rtl/lp_feeder_if.sv
// Upstream word stream, LP solver ports and result stream of lp_feeder.
// a1/a2/b and solver/result values are two's-complement bit patterns carried unchanged.
interface lp_feeder_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        in_valid;
  logic [5:0]  in_a1;
  logic [5:0]  in_a2;
  logic [11:0] in_b;
  logic        lp_out_valid;
  logic [11:0] lp_out_max_value;
  logic        res_valid;
  logic [11:0] res_value;
  logic [3:0]  res_tag;
  logic        res_err;

  modport slave (
    input  s_valid, s_data, lp_out_valid, lp_out_max_value,
    output s_ready, in_valid, in_a1, in_a2, in_b,
           res_valid, res_value, res_tag, res_err
  );

  modport master (
    output s_valid, s_data, lp_out_valid, lp_out_max_value,
    input  s_ready, in_valid, in_a1, in_a2, in_b,
           res_valid, res_value, res_tag, res_err
  );
endinterface

// File: rtl/lp_feeder.sv
// Two-slot buffer feeding 7-word LP problems to the solver and returning tagged results.
// Optional LP_FEEDER_CHECK_EN: reject problems lacking the four unit bounding rows.
module lp_feeder (
  input logic        clk,
  input logic        rst_n,
  lp_feeder_if.slave bus
);
  // state | meaning
  // IDLE  | wait for the oldest slot to fill
  // SEND  | present words 0..6 of the selected slot, one per cycle
  // WAIT  | wait for the solver result
  // ERR   | selected slot failed the row check; report it and free the slot
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]      state;
  logic [23:0]     mem [2][7];
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic [1:0][3:0] slot_tag;
  logic            wr_slot;
  logic            rd_slot;
  logic [2:0]      wr_cnt;
  logic [2:0]      snd_cnt;
  logic [3:0]      tag_cnt;
  logic            accept;
  logic            fill_done;
  logic            release_slot;
  logic            sel_ok;
  logic [23:0]     cur_word;

  assign bus.s_ready  = !full[wr_slot];
  assign accept       = bus.s_valid && bus.s_ready;
  assign fill_done    = accept && (wr_cnt == 3'd6);
  assign release_slot = ((state == WAIT) && bus.lp_out_valid) || (state == ERR);

  assign cur_word     = mem[rd_slot][snd_cnt];
  assign bus.in_valid = (state == SEND);
  assign bus.in_a1    = bus.in_valid ? cur_word[23:18] : 6'd0;
  assign bus.in_a2    = bus.in_valid ? cur_word[17:12] : 6'd0;
  assign bus.in_b     = bus.in_valid ? cur_word[11:0]  : 12'd0;

  // Slots fill and drain alternately, so rd_slot always points at the oldest full one.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_slot][wr_cnt] <= bus.s_data;
  end

`ifdef LP_FEEDER_CHECK_EN
  logic [3:0] rows_seen;

  always_comb begin
    rows_seen = 4'b0000;
    for (int i = 1; i < 7; i++) begin
      case (mem[rd_slot][3'(i)][23:12])
        {6'h01, 6'h00}: rows_seen[0] = 1'b1;
        {6'h3F, 6'h00}: rows_seen[1] = 1'b1;
        {6'h00, 6'h01}: rows_seen[2] = 1'b1;
        {6'h00, 6'h3F}: rows_seen[3] = 1'b1;
        default: ;
      endcase
    end
  end

  assign sel_ok = &rows_seen;
`else
  assign sel_ok = 1'b1;
`endif

  // A fill completion and a release touch different slots, so both can land in one cycle.
  always_comb begin
    full_nxt = full;
    if (release_slot) full_nxt[rd_slot] = 1'b0;
    if (fill_done)    full_nxt[wr_slot] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      full          <= 2'b00;
      slot_tag      <= '0;
      wr_slot       <= 1'b0;
      rd_slot       <= 1'b0;
      wr_cnt        <= 3'd0;
      snd_cnt       <= 3'd0;
      tag_cnt       <= 4'd0;
      bus.res_valid <= 1'b0;
      bus.res_value <= 12'd0;
      bus.res_tag   <= 4'd0;
      bus.res_err   <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      full          <= full_nxt;

      if (accept) begin
        if (fill_done) begin
          wr_cnt            <= 3'd0;
          wr_slot           <= !wr_slot;
          slot_tag[wr_slot] <= tag_cnt;
          tag_cnt           <= tag_cnt + 4'd1;
        end else begin
          wr_cnt <= wr_cnt + 3'd1;
        end
      end

      case (state)
        IDLE: begin
          if (full[rd_slot]) begin
            snd_cnt <= 3'd0;
            state   <= sel_ok ? SEND : ERR;
          end
        end
        SEND: begin
          if (snd_cnt == 3'd6) state <= WAIT;
          else                 snd_cnt <= snd_cnt + 3'd1;
        end
        WAIT: begin
          if (bus.lp_out_valid) begin
            bus.res_valid <= 1'b1;
            bus.res_value <= bus.lp_out_max_value;
            bus.res_tag   <= slot_tag[rd_slot];
            bus.res_err   <= 1'b0;
            rd_slot       <= !rd_slot;
            state         <= IDLE;
          end
        end
`ifdef LP_FEEDER_CHECK_EN
        ERR: begin
          bus.res_valid <= 1'b1;
          bus.res_value <= 12'd0;
          bus.res_tag   <= slot_tag[rd_slot];
          bus.res_err   <= 1'b1;
          rd_slot       <= !rd_slot;
          state         <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lp_feeder.sv
// Self-checking bench for lp_feeder: directed vector table, corner sequences and a
// randomized phase checked against a problem-level reference model.
module tb_lp_feeder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lp_feeder_if bus ();
  lp_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [6:0][23:0] w;
    logic [3:0]       tag;
    logic             err;
  } prob_t;

  typedef struct packed {
    logic [6:0][23:0] w;
    logic [11:0]      sol;
    logic [11:0]      exp_val;
    logic [3:0]       exp_tag;
    logic             exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model state, owned by the monitor process
  prob_t            exp_q[$];
  prob_t            mon_p;
  logic             front_bursted = 1'b0;
  logic [6:0][23:0] rx_w;
  int               rx_cnt = 0;
  logic [3:0]       tag_m = 4'd0;
  int               burst_idx = 0;
  logic             armed = 1'b0;
  int               wait_cnt = 0;
  logic             resp_now = 1'b0;
  logic             prev_resp = 1'b0;
  logic [11:0]      sol_val = 12'd0;
  int               res_count = 0;
  int               bursts_done = 0;
  logic [11:0]      last_val = 12'd0;
  logic [3:0]       last_tag = 4'd0;
  logic             last_err = 1'b0;

  // stimulus knobs
  logic             hold = 1'b0;
  logic             noise = 1'b0;
  logic [11:0]      fix_sol[$];
  vec_t             tab[$];
  vec_t             v;
  logic [6:0][23:0] rw;
  int               trip[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  function automatic logic [23:0] mkw(input int a1, input int a2, input int b);
    logic [31:0] x, y, z;
    x = a1; y = a2; z = b;
    return {x[5:0], y[5:0], z[11:0]};
  endfunction

  function automatic logic model_err(input logic [6:0][23:0] w);
`ifdef LP_FEEDER_CHECK_EN
    logic r0, r1, r2, r3;
    int a1, a2;
    r0 = 0; r1 = 0; r2 = 0; r3 = 0;
    for (int i = 1; i < 7; i++) begin
      a1 = int'($signed(w[i][23:18]));
      a2 = int'($signed(w[i][17:12]));
      if (a1 == 1  && a2 == 0)  r0 = 1;
      if (a1 == -1 && a2 == 0)  r1 = 1;
      if (a1 == 0  && a2 == 1)  r2 = 1;
      if (a1 == 0  && a2 == -1) r3 = 1;
    end
    return !(r0 && r1 && r2 && r3);
`else
    return (w[0] !== w[0]);
`endif
  endfunction

  // monitor, solver model and scoreboard, all sampled on the falling edge
  initial begin
    bus.lp_out_valid     = 1'b0;
    bus.lp_out_max_value = 12'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs",
            {bus.s_ready, bus.in_valid, bus.in_a1, bus.in_a2, bus.in_b,
             bus.res_valid, bus.res_value, bus.res_tag, bus.res_err},
            {1'b1, 43'd0});
        exp_q.delete();
        front_bursted = 0; rx_cnt = 0; tag_m = 0; burst_idx = 0;
        armed = 0; prev_resp = 0; bus.lp_out_valid = 0;
      end else begin
        if (bus.res_valid) begin
          if (exp_q.size() == 0) fail("unexpected_result");
          else begin
            mon_p = exp_q.pop_front();
            if (!mon_p.err && !prev_resp) fail("result_timing");
            chk("res_value", bus.res_value, mon_p.err ? 12'd0 : sol_val);
            chk("res_tag", bus.res_tag, mon_p.tag);
            chk("res_err", bus.res_err, mon_p.err);
            front_bursted = 0;
            last_val = bus.res_value; last_tag = bus.res_tag; last_err = bus.res_err;
            res_count++;
          end
        end else if (prev_resp) fail("missing_result");

        resp_now = 0;
        bus.lp_out_valid = 1'b0;
        bus.lp_out_max_value = 12'($urandom);
        if (armed && !hold) begin
          if (wait_cnt == 0) begin
            sol_val = (fix_sol.size() != 0) ? fix_sol.pop_front() : 12'($urandom);
            bus.lp_out_valid = 1'b1;
            bus.lp_out_max_value = sol_val;
            resp_now = 1; armed = 0;
          end else wait_cnt--;
        end else if (noise && bus.in_valid) begin
          bus.lp_out_valid = 1'b1;
        end

        if (bus.in_valid) begin
          if (prev_resp) fail("idle_gap");
          if (exp_q.size() == 0 || exp_q[0].err || front_bursted) fail("unexpected_burst");
          else begin
            chk("burst_word", {bus.in_a1, bus.in_a2, bus.in_b}, exp_q[0].w[burst_idx]);
            burst_idx++;
            if (burst_idx == 7) begin
              front_bursted = 1; burst_idx = 0; armed = 1;
              wait_cnt = $urandom_range(0, 4);
              bursts_done++;
            end
          end
        end else begin
          chk("idle_bus_zero", {bus.in_a1, bus.in_a2, bus.in_b}, 24'd0);
          if (burst_idx != 0) begin fail("burst_broken"); burst_idx = 0; end
        end

        if (bus.s_valid && bus.s_ready) begin
          rx_w[rx_cnt] = bus.s_data;
          rx_cnt++;
          if (rx_cnt == 7) begin
            mon_p.w = rx_w; mon_p.tag = tag_m; mon_p.err = model_err(rx_w);
            exp_q.push_back(mon_p);
            tag_m++; rx_cnt = 0;
          end
        end
        prev_resp = resp_now;
      end
    end
  end

  // all stimulus tasks start and end just after a rising edge
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put_word(input logic [23:0] w);
    int n;
    logic r;
    n = 0;
    bus.s_valid = 1'b1; bus.s_data = w;
    forever begin
      @(negedge clk); r = bus.s_ready;
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n >= 2000) begin fail("ready_timeout"); break; end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic send_problem(input logic [6:0][23:0] w, input logic gaps);
    for (int i = 0; i < 7; i++) begin
      put_word(w[i]);
      if (gaps) idle($urandom_range(0, 1));
    end
  endtask

  task automatic wait_results(input int target);
    int n;
    n = 0;
    while (res_count < target && n < 3000) begin @(posedge clk); #1; n++; end
    if (res_count < target) fail("result_timeout");
  endtask

  task automatic wait_bursts(input int target);
    int n;
    n = 0;
    while (bursts_done < target && n < 3000) begin @(posedge clk); #1; n++; end
    if (bursts_done < target) fail("burst_timeout");
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_immediate",
        {bus.s_ready, bus.in_valid, bus.in_a1, bus.in_a2, bus.in_b,
         bus.res_valid, bus.res_value, bus.res_tag, bus.res_err},
        {1'b1, 43'd0});
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input int t[21], input int sol, input int val, input logic err);
    for (int i = 0; i < 7; i++) v.w[i] = mkw(t[3*i], t[3*i+1], t[3*i+2]);
    v.sol = 12'(sol); v.exp_val = 12'(val); v.exp_tag = 4'(tab.size()); v.exp_err = err;
    tab.push_back(v);
  endtask

  task automatic run_vec(input vec_t tv);
    int base, b0;
    base = res_count; b0 = bursts_done;
    if (!tv.exp_err) fix_sol.push_back(tv.sol);
    send_problem(tv.w, 1'b0);
    wait_results(base + 1);
    chk("tab_value", last_val, tv.exp_val);
    chk("tab_tag", last_tag, tv.exp_tag);
    chk("tab_err", last_err, tv.exp_err);
    chk("tab_burst", bursts_done - b0, tv.exp_err ? 0 : 1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = 24'd0;

    trip = '{1,1,0, 1,0,3, -1,0,0, 0,1,3, 0,-1,0, 1,1,4, 1,-1,2};
    add_vec(trip, 4, 4, 1'b0);
    trip = '{-32,31,-2048, 1,0,5, -1,0,-2048, 0,1,7, 0,-1,0, 31,-32,2047, -32,-32,-1};
    add_vec(trip, -7, -7, 1'b0);
`ifdef LP_FEEDER_CHECK_EN
    trip = '{2,3,0, 1,0,5, -1,0,5, 0,1,5, 0,1,9, 1,1,8, -1,-1,0};
    add_vec(trip, 99, 0, 1'b1);
`endif
    trip = '{5,-3,100, 0,-1,1, 0,1,6, -1,0,2, 1,0,9, 2,3,30, -4,1,-5};
    add_vec(trip, 2047, 2047, 1'b0);

    @(posedge clk); #1;
    do_reset();

    // directed vectors; solver noise during SEND must be ignored
    for (int i = 0; i < tab.size(); i++) begin
      noise = (i == 1);
      run_vec(tab[i]);
    end
    noise = 1'b0;

    // back-to-back problems with the first result held off
    do_reset();
    hold = 1'b1;
    base = res_count;
    send_problem(tab[0].w, 1'b0);
    send_problem(tab[0].w, 1'b0);
    chk("ready_low_both_full", bus.s_ready, 1'b0);
    idle(10);
    chk("ready_still_low", bus.s_ready, 1'b0);
    chk("no_result_while_held", res_count, base);
    hold = 1'b0;
    send_problem(tab[0].w, 1'b0);
    wait_results(base + 3);
    chk("third_tag", last_tag, 4'd2);

    // reset after word 3, then a fresh problem
    put_word(tab[0].w[0]); put_word(tab[0].w[1]);
    put_word(tab[0].w[2]); put_word(tab[0].w[3]);
    do_reset();
    run_vec(tab[0]);

    // reset while waiting for the solver
    hold = 1'b1;
    base = res_count;
    send_problem(tab[0].w, 1'b0);
    wait_bursts(bursts_done + 1);
    idle(2);
    do_reset();
    hold = 1'b0;
    idle(20);
    chk("no_result_after_reset", res_count, base);
    run_vec(tab[0]);

    // randomized stream, enough problems to wrap the tag
    do_reset();
    noise = 1'b1;
    base = res_count;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 7; i++) rw[i] = 24'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rw[1] = mkw(0, -1, $urandom_range(0, 50));
        rw[2] = mkw(1, 0, $urandom_range(0, 50));
        rw[4] = mkw(0, 1, $urandom_range(0, 50));
        rw[6] = mkw(-1, 0, $urandom_range(0, 50));
      end
      send_problem(rw, 1'b1);
    end
    wait_results(base + 20);
    chk("tag_wrap", last_tag, 4'd3);
    noise = 1'b0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
